// File: rtl/count_sched_pkg.sv
// Shared types for the two-requester even/odd counting scheduler.
package count_sched_pkg;

  localparam int WIDTH_D = 4;
  localparam int STEPW_D = 4;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} sched_state_t;

  typedef struct packed {
    logic               ud;
    logic               oe;
    logic [WIDTH_D-1:0] start;
    logic [STEPW_D-1:0] steps;
  } sched_cmd_t;

endpackage

// File: rtl/count_sched_step_core.sv
// Counter datapath: parity alignment on load, +/-2 per step, modulo 2^WIDTH.
module count_step_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             ud,
  input  logic             oe,
  input  logic [WIDTH-1:0] start,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] aligned;
  logic [WIDTH-1:0] stepped;

  // Nudging by one toward the count direction fixes parity without reversing travel.
  always_comb begin
    aligned = start;
    if (start[0] != oe) aligned = ud ? start + WIDTH'(1) : start - WIDTH'(1);
    stepped = ud ? out + WIDTH'(2) : out - WIDTH'(2);
  end

  always_ff @(posedge clk) begin
    if (rst)       out <= '0;
    else if (load) out <= aligned;
    else if (step) out <= stepped;
  end

endmodule

// File: rtl/count_sched.sv
// Round-robin scheduler sharing one up/down even/odd counter between two requesters.
// Optional abort support is built when COUNT_SCHED_ABORT_EN is defined.
module count_sched
  import count_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int STEPW = STEPW_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_ud,
  input  logic             req0_oe,
  input  logic [WIDTH-1:0] req0_start,
  input  logic [STEPW-1:0] req0_steps,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_ud,
  input  logic             req1_oe,
  input  logic [WIDTH-1:0] req1_start,
  input  logic [STEPW-1:0] req1_steps,
`ifdef COUNT_SCHED_ABORT_EN
  input  logic             abort,
  output logic             done_abort,
`endif
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             owner,
  output logic             done,
  output logic             done_id
);

  sched_state_t     state;
  sched_cmd_t       cmd, cmd0, cmd1;
  logic [STEPW-1:0] steps_left;
  logic             last;
  logic             grant0, grant1;
  logic             stop;

  assign cmd0 = '{ud: req0_ud, oe: req0_oe, start: req0_start, steps: req0_steps};
  assign cmd1 = '{ud: req1_ud, oe: req1_oe, start: req1_start, steps: req1_steps};

  // On a tie the requester not served last wins; last resets to 1 so req0 wins first.
  assign grant0 = req0_valid & (~req1_valid | last);
  assign grant1 = req1_valid & (~req0_valid | ~last);

  assign req0_ready = en & (state == IDLE) & grant0;
  assign req1_ready = en & (state == IDLE) & grant1;

`ifdef COUNT_SCHED_ABORT_EN
  assign stop = abort;
`else
  assign stop = 1'b0;
`endif

  count_step_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (en & (state == LOAD) & ~stop),
    .step  (en & (state == RUN) & ~stop),
    .ud    (cmd.ud),
    .oe    (cmd.oe),
    .start (cmd.start),
    .out   (out)
  );

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign done_id = done & owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd        <= '0;
      steps_left <= '0;
      owner      <= 1'b0;
      last       <= 1'b1;
`ifdef COUNT_SCHED_ABORT_EN
      done_abort <= 1'b0;
`endif
    end else if (en) begin
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            cmd   <= grant1 ? cmd1 : cmd0;
            owner <= grant1;
            last  <= grant1;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (stop) begin
            state <= DONE;
`ifdef COUNT_SCHED_ABORT_EN
            done_abort <= 1'b1;
`endif
          end else begin
            steps_left <= cmd.steps;
            state      <= (cmd.steps != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (stop) begin
            state <= DONE;
`ifdef COUNT_SCHED_ABORT_EN
            done_abort <= 1'b1;
`endif
          end else begin
            steps_left <= steps_left - STEPW'(1);
            if (steps_left == STEPW'(1)) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
`ifdef COUNT_SCHED_ABORT_EN
          done_abort <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/count_sched.md
# count_sched

Round-robin scheduler that shares one up/down, even/odd counting datapath between two requesters. Each requester issues a command: direction, parity, start value and step count. The block aligns the start value to the requested parity, steps the count by ±2 per enabled cycle, and signals completion to the owning requester. It sits between command sources (sequencers, test controllers) and the counter output `out`.

## Interface
- `WIDTH`, 4, counter width; arithmetic is modulo 2^WIDTH.
- `STEPW`, 4, width of the step-count field.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  global enable; when low, all registers hold and both `ready` outputs are 0.
- `req0_valid`, `req1_valid`  in  1  command offered.
- `req0_ready`, `req1_ready`  out  1  command accepted this cycle when valid&ready.
- `reqN_ud`  in  1  1 = count up, 0 = count down.
- `reqN_oe`  in  1  1 = odd sequence, 0 = even sequence.
- `reqN_start`  in  WIDTH  start value.
- `reqN_steps`  in  STEPW  number of ±2 steps after alignment.
- `out`  out  WIDTH  current count.
- `busy`  out  1  high in LOAD/RUN/DONE.
- `owner`  out  1  requester index of the active/last command.
- `done`  out  1  high while the FSM is in DONE.
- `done_id`  out  1  equals `owner` while `done` is high.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: `reqN_ready = en & grantN` (combinational).
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester not served last.
  - On a transfer, the command is captured, `owner` is updated, and the FSM moves to LOAD.
- LOAD: `out` is loaded with `start` if `start[0]` already matches `oe`; otherwise with `start+1` (ud=1) or `start-1` (ud=0), mod 2^WIDTH.
  - `steps_left = steps`.
  - The FSM moves to RUN if steps>0, else to DONE.
- RUN: each enabled cycle, `out ± 2` (mod 2^WIDTH; parity preserved) and `steps_left` decrements.
  - When `steps_left == 1` at the update, the FSM moves to DONE.
- DONE: `done = 1`, `done_id = owner`; the FSM returns to IDLE next enabled cycle.
- `out` holds its last value in IDLE.
- Reset values: state IDLE, `out = 0`, `busy = 0`, `done = 0`, `owner = 0`, `done_id = 0`, last-served = 1 (req0 wins the first tie).
- Boundary conditions:
  - Wrap: down from 0 by 2 gives 2^WIDTH−2; up from 2^WIDTH−1 by 2 gives 1.
  - A requester dropping valid is permitted only while ready is low; commands are never lost or duplicated.
  - `en` low in any state freezes state, `out`, `steps_left` and `done`; `done` is stretched, not repeated.
  - `rst` mid-command: the command is abandoned, no `done`, reset values apply next cycle.

## Timing
- Accept in cycle T.
- `out` = aligned value from T+2.
- Step k is visible at T+2+k.
- `done` is high in cycle T+2+steps.
- The next accept is possible in T+3+steps.
- With steps=0, `done` is high in T+2.
- Each cycle with `en` low delays every later event by one cycle.
- No back-to-back accepts; throughput is one command per steps+3 cycles.

## Configuration
- `COUNT_SCHED_ABORT_EN` defined:
  - Adds port `abort` (in, 1) and port `done_abort` (out, 1).
  - `abort = 1` with `en = 1` in LOAD or RUN forces DONE next cycle, with `out` frozen at its current value and `done_abort = 1` alongside `done`.
  - `done_abort` is 0 otherwise and resets to 0.
  - `abort` in IDLE or DONE is ignored.
- `COUNT_SCHED_ABORT_EN` undefined: both ports are absent and commands always run to completion.

## Structure
- Package `count_sched_pkg`:
  - State enum `sched_state_t` (IDLE, LOAD, RUN, DONE).
  - Command struct `sched_cmd_t` {ud, oe, start, steps}; start and steps widths come from package constants matching the parameter defaults.
- Sub-module `count_step_core`:
  - Owns the `out` register.
  - Inputs: load, step, ud, oe, start.
  - Performs parity alignment on load and the ±2 step.
- Arbiter and FSM live in `count_sched`.

## Test plan
- Reset, then req0 ud=1 oe=1 start=4 steps=3 → `out` 5,7,9,11 at T+2..T+5; `done` high at T+5, `done_id = 0`.
- req1 ud=0 oe=0 start=3 steps=2 → `out` 2,0,14; `done_id = 1`.
- Both valid with identical commands, held → req0 granted first, then req1, then req0; `owner` alternates 0,1,0.
- req0 ud=0 oe=1 start=6 steps=0 → `out` = 5 at T+2, `done` at T+2, IDLE at T+3.
- req0 start=0 steps=4 ud=1 oe=0, with `en` low for 3 cycles during RUN → `out` and `steps_left` frozen; `done` at T+9 (T+6 nominal + 3).
- `rst` pulsed mid-RUN → next cycle `out = 0`, `busy = 0`, no `done`; a subsequent tie is granted to req0.
